// File: rtl/brightness_pkg.sv
// -----------------------------------------------------------------------------
// brightness_pkg
// Shared definitions for the brightness pipeline (loader, PE array and
// result writer): default datapath widths and the result-writer FSM states.
// -----------------------------------------------------------------------------
package brightness_pkg;

    // Default datapath geometry
    localparam int RAM_ADDR_WIDTH_DEF = 6;   // 64-byte frame
    localparam int RAM_DATA_WIDTH_DEF = 8;   // one pixel per RAM word
    localparam int PE_DATA_WIDTH_DEF  = 16;  // one PE accumulator lane
    localparam int DEPTH_DEF          = 4;   // lanes per result vector

    // Result vectors buffered between the PE array and the RAM port
    localparam int RW_FIFO_ENTRIES    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        DONE_ST = 2'd2
    } state_t;

endpackage : brightness_pkg

// File: rtl/pixel_clamp.sv
// -----------------------------------------------------------------------------
// pixel_clamp
// Combinational conversion of one PE result lane into one RAM pixel.
//
// Optional feature macro: SATURATE_EN
//   defined   : lane is signed; negatives give 0, values above the pixel
//               maximum give all-ones, everything else passes its low bits.
//   undefined : lane is truncated to its low RAM_DATA_WIDTH bits.
//
// Ports
//   lane_i [PE_DATA_WIDTH-1:0]  : PE result lane
//   pix_o  [RAM_DATA_WIDTH-1:0] : pixel value to write
// -----------------------------------------------------------------------------
module pixel_clamp
    import brightness_pkg::*;
#(
    parameter int PE_DATA_WIDTH  = PE_DATA_WIDTH_DEF,
    parameter int RAM_DATA_WIDTH = RAM_DATA_WIDTH_DEF
) (
    input  logic [PE_DATA_WIDTH-1:0]  lane_i,
    output logic [RAM_DATA_WIDTH-1:0] pix_o
);

`ifdef SATURATE_EN
    // Largest pixel value expressed in the lane's signed domain
    localparam logic signed [PE_DATA_WIDTH-1:0] PIX_MAX =
        PE_DATA_WIDTH'((1 << RAM_DATA_WIDTH) - 1);

    always_comb begin
        pix_o = lane_i[RAM_DATA_WIDTH-1:0];
        if (lane_i[PE_DATA_WIDTH-1]) begin
            pix_o = '0;
        end else if ($signed(lane_i) > PIX_MAX) begin
            pix_o = '1;
        end
    end
`else
    // Upper lane bits are intentionally discarded in truncation mode
    logic unused_hi;
    assign unused_hi = ^lane_i[PE_DATA_WIDTH-1:RAM_DATA_WIDTH];
    assign pix_o     = lane_i[RAM_DATA_WIDTH-1:0];
`endif

endmodule : pixel_clamp

// File: rtl/result_writer.sv
// -----------------------------------------------------------------------------
// result_writer
// Drains PE result vectors into a byte-wide frame RAM. After start, each
// accepted vector is written lane 0..DEPTH-1 at consecutive addresses from 0,
// one byte per cycle, until the last frame address is written; done then
// pulses for one cycle. A 2-entry vector FIFO absorbs bursts; a vector
// offered while the FIFO is full is dropped and flags overflow (sticky until
// the next start or reset).
//
// Optional feature macro: SATURATE_EN (see pixel_clamp) selects saturating
// instead of truncating lane-to-pixel conversion.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   start        : begin a frame (honoured in IDLE only)
//   data_in      : result vector, lane i at [i*PE_DATA_WIDTH +: PE_DATA_WIDTH]
//   data_valid   : data_in valid this cycle
//   ready        : a vector can be accepted this cycle
//   ram_address  : registered write address
//   ram_wdata    : registered write data
//   ram_we       : registered write strobe
//   done         : one-cycle frame-complete pulse
//   overflow     : sticky dropped-vector flag
// -----------------------------------------------------------------------------
module result_writer
    import brightness_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
    parameter int RAM_DATA_WIDTH = RAM_DATA_WIDTH_DEF,
    parameter int PE_DATA_WIDTH  = PE_DATA_WIDTH_DEF,
    parameter int DEPTH          = DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [PE_DATA_WIDTH*DEPTH-1:0]  data_in,
    input  logic                            data_valid,
    output logic                            ready,
    output logic [RAM_ADDR_WIDTH-1:0]       ram_address,
    output logic [RAM_DATA_WIDTH-1:0]       ram_wdata,
    output logic                            ram_we,
    output logic                            done,
    output logic                            overflow
);

    localparam int LANE_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LANE_W-1:0]         LAST_LANE = LANE_W'(DEPTH - 1);
    localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef logic [DEPTH-1:0][PE_DATA_WIDTH-1:0] vec_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                       state_q, state_d;
    logic [LANE_W-1:0]            lane_q, lane_d;
    logic [RAM_ADDR_WIDTH-1:0]    write_addr_q, write_addr_d;
    logic                         overflow_q, overflow_d;
    logic                         done_q, done_d;
    logic                         ram_we_q, ram_we_d;
    logic [RAM_ADDR_WIDTH-1:0]    ram_address_q, ram_address_d;
    logic [RAM_DATA_WIDTH-1:0]    ram_wdata_q, ram_wdata_d;

    vec_t [RW_FIFO_ENTRIES-1:0]   fifo_q;
    logic                         wr_ptr_q, rd_ptr_q;
    logic [1:0]                   count_q;

    // ------------------------------------------------------------------
    // Handshake and byte selection
    // ------------------------------------------------------------------
    vec_t                                   in_vec;
    vec_t                                   src_vec;
    logic [DEPTH-1:0][RAM_DATA_WIDTH-1:0]   lane_pix;
    logic                                   push, pop, wr_byte, last_lane, clear;

    assign in_vec    = data_in;
    assign ready     = (state_q == WRITE) && (count_q < 2'(RW_FIFO_ENTRIES));
    assign push      = data_valid && ready;

    // An empty FIFO forwards the incoming vector so lane 0 is written in the
    // same edge that captures it; the vector still enters the FIFO and the
    // remaining lanes are read back from the head entry.
    assign src_vec   = (count_q == 2'd0) ? in_vec : fifo_q[rd_ptr_q];
    assign wr_byte   = (state_q == WRITE) && ((count_q != 2'd0) || push);
    assign last_lane = (lane_q == LAST_LANE);
    assign pop       = wr_byte && last_lane;

    for (genvar g = 0; g < DEPTH; g++) begin : g_lane
        pixel_clamp #(
            .PE_DATA_WIDTH  (PE_DATA_WIDTH),
            .RAM_DATA_WIDTH (RAM_DATA_WIDTH)
        ) u_clamp (
            .lane_i (src_vec[g]),
            .pix_o  (lane_pix[g])
        );
    end

    // ------------------------------------------------------------------
    // FSM next state and registered RAM port
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        write_addr_d  = write_addr_q;
        overflow_d    = overflow_q;
        clear         = 1'b0;
        ram_we_d      = 1'b0;
        ram_address_d = ram_address_q;
        ram_wdata_d   = ram_wdata_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = WRITE;
                    clear        = 1'b1;
                    lane_d       = '0;
                    write_addr_d = '0;
                    overflow_d   = 1'b0;
                end
            end

            WRITE: begin
                if (data_valid && !ready) begin
                    overflow_d = 1'b1;
                end
                if (wr_byte) begin
                    ram_we_d      = 1'b1;
                    ram_address_d = write_addr_q;
                    ram_wdata_d   = lane_pix[lane_q];
                    lane_d        = last_lane ? '0 : lane_q + 1'b1;
                    // Only the final byte wraps the counter, and the frame
                    // ends on that same edge.
                    write_addr_d  = write_addr_q + 1'b1;
                    if (write_addr_q == LAST_ADDR) begin
                        state_d = DONE_ST;
                    end
                end
            end

            DONE_ST: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    assign done_d = (state_d == DONE_ST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            lane_q        <= '0;
            write_addr_q  <= '0;
            overflow_q    <= 1'b0;
            done_q        <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_address_q <= '0;
            ram_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            write_addr_q  <= write_addr_d;
            overflow_q    <= overflow_d;
            done_q        <= done_d;
            ram_we_q      <= ram_we_d;
            ram_address_q <= ram_address_d;
            ram_wdata_q   <= ram_wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Vector FIFO (push and pop in one cycle both take effect)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clear) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= in_vec;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign ram_we      = ram_we_q;
    assign ram_address = ram_address_q;
    assign ram_wdata   = ram_wdata_q;
    assign done        = done_q;
    assign overflow    = overflow_q;

endmodule : result_writer

// File: tb/tb_result_writer.sv
// -----------------------------------------------------------------------------
// tb_result_writer
// Randomised scoreboard bench for result_writer. The stimulus side turns every
// accepted vector into the expected sequence of (address, pixel) writes; a
// separate monitor pops and compares on every ram_we, and checks done against
// the final frame address.
// -----------------------------------------------------------------------------
module tb_result_writer;

    localparam int AW     = 6;
    localparam int DW     = 8;
    localparam int PW     = 16;
    localparam int D      = 4;
    localparam int NBYTES = 1 << AW;
    localparam int NVEC   = NBYTES / D;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic            clk        = 1'b0;
    logic            reset      = 1'b0;
    logic            start      = 1'b0;
    logic            data_valid = 1'b0;
    logic [PW*D-1:0] data_in    = '0;
    logic            ready;
    logic [AW-1:0]   ram_address;
    logic [DW-1:0]   ram_wdata;
    logic            ram_we;
    logic            done;
    logic            overflow;

    int  checks    = 0;
    int  errors    = 0;
    int  n_writes  = 0;
    int  n_done    = 0;
    int  next_addr = 0;
    bit  exp_ovf   = 1'b0;
    wr_t exp_q[$];

    result_writer #(
        .RAM_ADDR_WIDTH (AW),
        .RAM_DATA_WIDTH (DW),
        .PE_DATA_WIDTH  (PW),
        .DEPTH          (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .ready       (ready),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Pixel a lane should become, straight from the conversion rule
    function automatic logic [DW-1:0] model_pix(input logic [PW-1:0] v);
`ifdef SATURATE_EN
        int s;
        s = int'($signed(v));
        if (s < 0)   return '0;
        if (s > 255) return 8'd255;
`endif
        return v[DW-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: every write must be the next expected one
    // ------------------------------------------------------------------
    always @(negedge clk) begin : mon
        wr_t e;
        if (!reset) begin
            if (ram_we) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %0h, no write expected",
                             ram_address, ram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(ram_address), 32'(e.addr));
                    chk("wr_data", 32'(ram_wdata), 32'(e.data));
                    chk("done_on_write", 32'(done), 32'(e.addr == AW'(NBYTES - 1)));
                end
            end else begin
                chk("done_without_write", 32'(done), 32'd0);
            end
            if (done) n_done++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at a falling edge)
    // ------------------------------------------------------------------
    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        next_addr = 0;
        exp_ovf   = 1'b0;
    endtask

    task automatic offer(input logic [PW*D-1:0] v, output bit acc);
        data_in    = v;
        data_valid = 1'b1;
        acc        = ready;
        if (acc) begin
            for (int i = 0; i < D; i++) begin
                exp_q.push_back('{addr: AW'(next_addr), data: model_pix(v[i*PW +: PW])});
                next_addr++;
            end
        end else begin
            exp_ovf = 1'b1;
        end
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [PW*D-1:0] rand_vec();
        return {$urandom(), $urandom()};
    endfunction

    task automatic wait_done(input string name, input int done_before);
        int budget;
        budget = 0;
        while (n_done == done_before && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        idle(3);
        chk({name, "_done_count"}, 32'(n_done - done_before), 32'd1);
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        chk({name, "_ready_idle"}, 32'(ready), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_we"}, 32'(ram_we), 32'd0);
        chk({name, "_addr"}, 32'(ram_address), 32'd0);
        chk({name, "_wdata"}, 32'(ram_wdata), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_ovf"}, 32'(overflow), 32'd0);
        chk({name, "_ready"}, 32'(ready), 32'd0);
    endtask

    // Frame with one vector every 4 cycles, lane value = its address
    task automatic frame_paced(input string name);
        bit acc;
        int d0;
        d0 = n_done;
        start_frame();
        for (int v = 0; v < NVEC; v++) begin
            offer({16'(4*v+3), 16'(4*v+2), 16'(4*v+1), 16'(4*v)}, acc);
            if (v == 0) begin
                chk({name, "_first_we"}, 32'(ram_we), 32'd1);
                chk({name, "_first_addr"}, 32'(ram_address), 32'd0);
            end
            idle(3);
        end
        wait_done(name, d0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : stim
        bit acc;
        int accepted;
        int budget;
        int base;
        int d0;

        #2 reset = 1'b1;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Paced frame, lane value = address
        frame_paced("paced");

        // Conversion corners, then random traffic with random gaps
        d0 = n_done;
        start_frame();
        chk("conv_start_ovf_clear", 32'(overflow), 32'd0);
        offer({16'h0000, 16'd255, 16'd300, 16'hFFF6}, acc);
        accepted = acc ? 1 : 0;
        budget = 0;
        while (accepted < NVEC && budget < 1000) begin
            if ($urandom_range(0, 2) == 0) begin
                idle($urandom_range(1, 4));
            end else begin
                offer(rand_vec(), acc);
                if (acc) accepted++;
            end
            budget++;
        end
        chk("random_accepted", 32'(accepted), 32'(NVEC));
        wait_done("random", d0);

        // data_valid held high for the whole frame
        d0 = n_done;
        start_frame();
        accepted = 0;
        budget = 0;
        while (accepted < NVEC && budget < 400) begin
            offer(rand_vec(), acc);
            if (budget == 2) chk("burst_ready_after_2", 32'(acc), 32'd0);
            if (acc) accepted++;
            budget++;
        end
        chk("burst_accepted", 32'(accepted), 32'(NVEC));
        chk("burst_ovf_expected", 32'(exp_ovf), 32'd1);
        wait_done("burst", d0);
        chk("burst_ovf_sticky_idle", 32'(overflow), 32'd1);

        // Reset in the middle of a frame
        start_frame();
        chk("restart_ovf_clear", 32'(overflow), 32'd0);
        base = n_writes;
        budget = 0;
        while (n_writes - base < 10 && budget < 200) begin
            offer(rand_vec(), acc);
            budget++;
        end
        chk("ten_writes_seen", 32'(n_writes - base >= 10), 32'd1);
        reset = 1'b1;
        #1 check_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(5);
        chk("post_reset_no_we", 32'(ram_we), 32'd0);
        frame_paced("after_reset");

        // data_valid in IDLE, then start pulsed during WRITE
        data_in    = rand_vec();
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        idle(3);
        chk("idle_valid_ovf", 32'(overflow), 32'd0);
        chk("idle_valid_ready", 32'(ready), 32'd0);

        d0 = n_done;
        start_frame();
        accepted = 0;
        budget = 0;
        while (accepted < NVEC && budget < 600) begin
            if (accepted == 3) begin
                start = 1'b1;
                offer(rand_vec(), acc);
                start = 1'b0;
            end else begin
                offer(rand_vec(), acc);
            end
            if (acc) accepted++;
            idle(3);
            budget++;
        end
        wait_done("start_in_write", d0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule : tb_result_writer

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter RAM_ADDR_WIDTH, default 6: output RAM address width; the frame is 2**RAM_ADDR_WIDTH bytes.
REQ-002 Parameter RAM_DATA_WIDTH, default 8: output pixel width.
REQ-003 Parameter PE_DATA_WIDTH, default 16: width of one PE result lane.
REQ-004 Parameter DEPTH, default 4: lanes per input vector (systolic array size).
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port start, input, 1: begin a frame write.
REQ-008 Port data_in, input, PE_DATA_WIDTH*DEPTH: result vector; lane i is bits [i*PE_DATA_WIDTH +: PE_DATA_WIDTH].
REQ-009 Port data_valid, input, 1: data_in is valid this cycle.
REQ-010 Port ready, output, 1: the block can accept a vector this cycle.
REQ-011 Port ram_address, output, RAM_ADDR_WIDTH: write address.
REQ-012 Port ram_wdata, output, RAM_DATA_WIDTH: write data.
REQ-013 Port ram_we, output, 1: write strobe.
REQ-014 Port done, output, 1: one-cycle pulse when the frame is complete.
REQ-015 Port overflow, output, 1: sticky flag; a vector was dropped.

Function
REQ-016 The FSM SHALL have three states: IDLE, WRITE and DONE_ST.
- IDLE -> WRITE on start.
- WRITE -> DONE_ST in the cycle the byte at address 2**RAM_ADDR_WIDTH-1 is written.
- DONE_ST -> IDLE unconditionally.
REQ-017 start SHALL be ignored outside IDLE; entering WRITE SHALL clear write_addr, the lane index, the FIFO and overflow.
REQ-018 The block SHALL buffer input in a 2-entry vector FIFO; ready = (state==WRITE) && (count<2), registered-free combinational.
REQ-019 A vector SHALL be pushed when data_valid && ready; data_valid && !ready in WRITE SHALL drop the vector and set overflow (sticky until the next start or reset).
REQ-020 data_valid in IDLE or DONE_ST SHALL be ignored without setting overflow.
REQ-021 While the FIFO is non-empty in WRITE, the block SHALL write one byte per cycle, lanes 0..DEPTH-1 of the head vector in order, at consecutive addresses from 0.
REQ-022 The head vector SHALL pop on its last lane; a push and a pop in the same cycle SHALL both take effect.
REQ-023 ram_address, ram_wdata and ram_we SHALL be registered; a vector pushed in cycle N into an empty FIFO SHALL produce ram_we=1 for lane 0 in cycle N+1.
REQ-024 ram_we SHALL be 0 whenever no byte is written; ram_address and ram_wdata SHALL hold their last value.
REQ-025 done SHALL be 1 for exactly the DONE_ST cycle; the address counter SHALL not wrap within a frame.

Reset
REQ-026 On reset the block SHALL set state=IDLE, empty the FIFO, and clear write_addr, the lane index, ram_address, ram_wdata, ram_we, done and overflow to 0.
REQ-027 Reset SHALL take effect immediately when asserted mid-frame; no further writes SHALL occur after reset.

Configuration
REQ-028 With SATURATE_EN defined, each lane SHALL be treated as signed: values <0 write 0, values >255 write 255, other values write the low 8 bits.
REQ-029 Without SATURATE_EN, each lane SHALL write its low RAM_DATA_WIDTH bits (truncation).

Structure
REQ-030 The FSM state_t enum and the default width constants SHALL live in brightness_pkg, shared with the loader and the PE array.
REQ-031 Per-lane conversion SHALL be the sub-module pixel_clamp, a pure combinational PE_DATA_WIDTH -> RAM_DATA_WIDTH converter honouring SATURATE_EN.

Verification
REQ-032 Start, then 16 vectors, one every 4 cycles, lane values = address -> 64 writes to addresses 0..63, done pulses once, overflow=0.
REQ-033 SATURATE_EN defined, lanes {16'hFFF6, 16'd300, 16'd255, 16'd0} -> bytes 0, 255, 255, 0; undefined -> bytes F6, 2C, FF, 00.
REQ-034 data_valid held high every cycle in WRITE -> ready drops after 2 pushes, overflow=1, and addresses remain contiguous for the accepted vectors.
REQ-035 Reset asserted after 10 writes -> ram_we=0 immediately and all outputs at reset values; a subsequent start rewrites from address 0.
REQ-036 start pulsed during WRITE and data_valid pulsed in IDLE -> no state change, no write, overflow=0.
